// File: rtl/tcdm_responder_pkg.sv
// Shared types and constants for the TCDM responder.
//
// Contents:
//   RESP_DATA_WIDTH - default data width of resp_t
//   resp_t          - one response beat: valid, rdata, opc
//   LFSR_SEED       - stall LFSR reset value
//   LFSR_TAPS       - tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   lfsr_feedback() - feedback bit of the Fibonacci LFSR (shifts left)
package tcdm_responder_pkg;

    localparam int unsigned RESP_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       valid;
        logic [RESP_DATA_WIDTH-1:0] rdata;
        logic                       opc;
    } resp_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-depth delay line for TCDM responses.
//
// Parameters:
//   Depth       - number of register stages (>= 1)
//   resp_elem_t - response struct type; must have fields valid, rdata, opc
// Ports:
//   clk_i  in   clock
//   rst_i  in   synchronous active-high clear of every stage
//   in_i   in   response entering the line
//   out_o  out  response leaving the line, Depth cycles later
//
// The valid bit shifts every cycle; rdata/opc move only alongside a valid
// beat, so the last stage keeps its payload between responses.
module tcdm_resp_pipe
    import tcdm_responder_pkg::*;
#(
    parameter int unsigned Depth = 1,
    parameter type resp_elem_t   = resp_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  resp_elem_t in_i,
    output resp_elem_t out_o
);

    resp_elem_t stage_q [Depth];
    resp_elem_t stage_d [Depth];
    resp_elem_t chain   [Depth+1];

    always_comb begin
        chain[0] = in_i;
        for (int unsigned k = 0; k < Depth; k++) begin
            chain[k+1] = stage_q[k];
        end
        for (int unsigned k = 0; k < Depth; k++) begin
            stage_d[k]       = stage_q[k];
            stage_d[k].valid = chain[k].valid;
            if (chain[k].valid) begin
                stage_d[k].rdata = chain[k].rdata;
                stage_d[k].opc   = chain[k].opc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < Depth; k++) begin
            if (rst_i) begin
                stage_q[k] <= '0;
            end else begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_responder.sv
// TCDM memory-side responder backed by a word-addressed register array.
//
// Parameters: ADDR_WIDTH, DATA_WIDTH (power of two, >= 8),
//             MEM_WORDS (power of two), RESP_LATENCY (>= 1)
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   tcdm_req_i           request
//   tcdm_gnt_o           grant, combinational from req and stall
//   tcdm_add_i           byte address
//   tcdm_wen_i           1 = read, 0 = write
//   tcdm_be_i            write byte enables
//   tcdm_wdata_i         write data
//   tcdm_r_rdata_o       read data (0 for writes and out-of-range)
//   tcdm_r_valid_o       one-cycle response pulse, RESP_LATENCY after grant
//   tcdm_r_opc_o         1 = address out of range
//   gnt_count_o          saturating count of accepted transactions
//
// Build option: define TCDM_RESPONDER_STALL_EN to suppress grants with an
// 8-bit LFSR (stall when lfsr[1:0] == 0). Undefined: grant = request.
module tcdm_responder
    import tcdm_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_WORDS    = 256,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tcdm_req_i,
    output logic                    tcdm_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
    output logic [DATA_WIDTH-1:0]   tcdm_r_rdata_o,
    output logic                    tcdm_r_valid_o,
    output logic                    tcdm_r_opc_o,
    output logic [15:0]             gnt_count_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned Off      = $clog2(NumBytes);
    localparam int unsigned Idx      = $clog2(MEM_WORDS);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  opc;
    } resp_w_t;

    logic                  stall;
    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [Idx-1:0]        word_idx;
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [15:0]           gnt_count_q, gnt_count_d;
    resp_w_t               resp_in, resp_out;

    // Stall source
`ifdef TCDM_RESPONDER_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Grant stays combinational even in reset; acceptance is what reset masks.
    assign tcdm_gnt_o = tcdm_req_i && !stall;
    assign accept     = tcdm_req_i && tcdm_gnt_o && !rst_i;

    // Address decode: byte offset bits are dropped, anything past the array
    // end is an error response.
    assign word_addr = tcdm_add_i >> Off;
    assign word_idx  = tcdm_add_i[Off +: Idx];
    assign in_range  = (word_addr < ADDR_WIDTH'(MEM_WORDS));

    // Memory array, intentionally without reset
    always_ff @(posedge clk_i) begin
        if (accept && in_range && !tcdm_wen_i) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (tcdm_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= tcdm_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response formed at acceptance; the read sees pre-edge contents.
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.opc   = !in_range;
        if (in_range && tcdm_wen_i) begin
            resp_in.rdata = mem_q[word_idx];
        end
    end

    tcdm_resp_pipe #(
        .Depth       (RESP_LATENCY),
        .resp_elem_t (resp_w_t)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (resp_in),
        .out_o (resp_out)
    );

    assign tcdm_r_valid_o = resp_out.valid;
    assign tcdm_r_rdata_o = resp_out.rdata;
    assign tcdm_r_opc_o   = resp_out.opc;

    // Saturating acceptance counter
    always_comb begin
        gnt_count_d = gnt_count_q;
        if (accept && (gnt_count_q != 16'hFFFF)) begin
            gnt_count_d = gnt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_count_q <= 16'd0;
        end else begin
            gnt_count_q <= gnt_count_d;
        end
    end

    assign gnt_count_o = gnt_count_q;

endmodule
